// File: rtl/ps2_device_tx.sv
// ps2_device_tx: device-side PS/2 transmitter. A byte FIFO feeds an 11-bit frame serialiser on ps2_clk/ps2_data.
// Defining PS2_HOST_INHIBIT_EN enables host-inhibit sensing on host_clk_in (hold-off and abort/resend).
module ps2_device_tx #(
  parameter int HALF_PERIOD = 1280,
  parameter int FIFO_DEPTH  = 16,
  parameter int GAP_CYCLES  = 2560
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        ps2_clk,
  output logic                        ps2_data,
  input  logic                        host_clk_in,
  output logic [2:0]                  dbg_state
);
  // Handshake: din is taken on every clk edge where din_valid && din_ready. din_ready is
  // registered and depends only on the fill level; a byte offered while it is low is lost.

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HP_LOAD  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(1);
  localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_LOW   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          r_ready;
  logic          w_push;
  logic          w_pop;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [9:0]    r_shift;
  logic          r_clk;
  logic          r_data;
  logic [7:0]    w_head;
  logic [10:0]   w_frame;
  logic          w_hs;
  logic          w_start_ok;
  logic          w_abort;

  assign w_push  = din_valid && r_ready;
  assign w_pop   = (r_state == S_LOW) && (r_cnt == '0) && (r_bit == 4'd10);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_frame = {1'b1, ~^w_head, w_head, 1'b0};

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop) w_count_next = r_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_next;
      r_ready <= (w_count_next != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

`ifdef PS2_HOST_INHIBIT_EN
  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam logic [HW-1:0] HS_FULL = HW'(HALF_PERIOD);
  localparam logic [HW-1:0] HS_INC  = HW'(1);

  logic [1:0]    r_hs_sync;
  logic [HW-1:0] r_hs_cnt;

  // Saturating count of consecutive synchronised-high cycles gates the start of a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_sync <= 2'b00;
      r_hs_cnt  <= '0;
    end else begin
      r_hs_sync <= {r_hs_sync[0], host_clk_in};
      if (!r_hs_sync[1])           r_hs_cnt <= '0;
      else if (r_hs_cnt != HS_FULL) r_hs_cnt <= r_hs_cnt + HS_INC;
    end
  end

  assign w_hs       = r_hs_sync[1];
  assign w_start_ok = (r_hs_cnt == HS_FULL);
`else
  logic w_unused_host_clk;
  assign w_unused_host_clk = host_clk_in;
  assign w_hs              = 1'b1;
  assign w_start_ok        = 1'b1;
`endif

  // Bit 10 and the gap are never aborted: once the stop bit is on the wire the byte is delivered.
  assign w_abort = !w_hs && (r_bit <= 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_clk   <= 1'b1;
      r_data  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0 && w_start_ok) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift <= w_frame[10:1];
          r_bit   <= 4'd0;
          r_data  <= w_frame[0];
          r_clk   <= 1'b1;
          r_cnt   <= HP_LOAD;
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (w_abort) begin
            r_clk   <= 1'b1;
            r_data  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_clk   <= 1'b0;
            r_cnt   <= HP_LOAD;
            r_state <= S_LOW;
          end else begin
            r_cnt <= r_cnt - CNT_DEC;
          end
        end
        S_LOW: begin
          if (r_cnt == '0) begin
            r_clk <= 1'b1;
            if (r_bit == 4'd10) begin
              r_data  <= 1'b1;
              r_cnt   <= GAP_LOAD;
              r_state <= S_GAP;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_data  <= r_shift[0];
              r_shift <= {1'b1, r_shift[9:1]};
              r_cnt   <= HP_LOAD;
              r_state <= S_SETUP;
            end
          end else begin
            r_cnt <= r_cnt - CNT_DEC;
          end
        end
        S_GAP: begin
          // Going straight to LOAD keeps back-to-back frames exactly one frame time apart.
          if (r_cnt == '0) begin
            if (r_count != '0 && w_start_ok) r_state <= S_LOAD;
            else                             r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_DEC;
          end
        end
        default: begin
          r_clk   <= 1'b1;
          r_data  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign din_ready  = r_ready;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign ps2_clk    = r_clk;
  assign ps2_data   = r_data;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: a line monitor decodes frames, scenario tasks check them inline.
// Runs in both builds; the host-inhibit scenario selects its expectations with PS2_HOST_INHIBIT_EN.
module tb_ps2_device_tx;
  localparam int HP        = 4;
  localparam int GAP       = 8;
  localparam int DEPTH     = 16;
  localparam int FRAME_CYC = 1 + 22 * HP + GAP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       host_clk_in = 1'b1;
  logic       din_ready;
  logic [4:0] fifo_count;
  logic       busy;
  logic       ps2_clk;
  logic       ps2_data;
  logic [2:0] dbg_state;

  ps2_device_tx #(.HALF_PERIOD(HP), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .fifo_count(fifo_count), .busy(busy), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .host_clk_in(host_clk_in), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] rx_q[$];
  int          rx_start_q[$];

  // Line monitor: frame bit i is ps2_data at the i-th ps2_clk fall.
  int          cyc = 0;
  int          low_err = 0;
  int          aborts = 0;
  int          m_n = 0;
  int          m_low = 0;
  int          m_high = 0;
  logic        m_prev = 1'b1;
  logic        m_data = 1'b1;
  logic [10:0] m_sh = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_n = 0; m_low = 0; m_high = 0; m_prev = 1'b1;
    end else begin
      if (m_prev && !ps2_clk) begin
        if (m_n == 0) rx_start_q.push_back(cyc);
        if (m_n < 11) m_sh[m_n] = ps2_data;
        m_data = ps2_data;
        m_n++;
        m_low = 1;
      end else if (!ps2_clk) begin
        m_low++;
        if (ps2_data !== m_data) low_err++;
      end else if (!m_prev && ps2_clk) begin
        if (m_low != HP) low_err++;
        if (m_n == 11) begin
          rx_q.push_back(m_sh);
          m_n = 0;
        end
        m_high = 1;
      end else begin
        m_high++;
        if (m_n != 0 && m_high > HP + 2) begin
          aborts++;
          m_n = 0;
        end
      end
      m_prev = ps2_clk;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    din = b;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    host_clk_in = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ps2_clk !== 1'b1) begin n_bad++; $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk); end
    n_cmp++; if (ps2_data !== 1'b1) begin n_bad++; $display("FAIL reset_ps2_data: got %b want 1", ps2_data); end
    n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    bit ok;
    rx_q.delete(); rx_start_q.delete(); low_err = 0;
    push_byte(8'h1C);
    n_cmp++; if (fifo_count !== 5'd1) begin n_bad++; $display("FAIL sf_count_after_push: got %0d want 1", fifo_count); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sf_busy_after_push: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (ps2_data !== 1'b1) begin n_bad++; $display("FAIL sf_data_load: got %b want 1", ps2_data); end
    @(negedge clk);
    n_cmp++; if (ps2_data !== 1'b0) begin n_bad++; $display("FAIL sf_start_latency: got %b want 0", ps2_data); end
    n_cmp++; if (ps2_clk !== 1'b1) begin n_bad++; $display("FAIL sf_clk_setup: got %b want 1", ps2_clk); end
    wait_rx(1, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sf_frame_timeout: got %0d frames want 1", rx_q.size()); end
    if (ok) begin
      n_cmp++; if (rx_q[0] !== 11'b10000111000) begin n_bad++; $display("FAIL sf_bits_1C: got %b want 10000111000", rx_q[0]); end
    end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL sf_pop: got %0d want 0", fifo_count); end
    repeat (7) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL sf_busy_in_gap: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sf_busy_after_gap: got %b want 0", busy); end
    n_cmp++; if (rx_q.size() !== 1) begin n_bad++; $display("FAIL sf_frame_count: got %0d want 1", rx_q.size()); end
    n_cmp++; if (low_err !== 0) begin n_bad++; $display("FAIL sf_low_phase: got %0d bad low phases want 0", low_err); end
  endtask

  task automatic test_parity();
    bit ok;
    rx_q.delete(); rx_start_q.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h01);
    wait_rx(3, 3 * FRAME_CYC + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL par_timeout: got %0d frames want 3", rx_q.size()); end
    if (ok) begin
      n_cmp++; if (rx_q[0] !== 11'b11000000000) begin n_bad++; $display("FAIL par_00: got %b want 11000000000", rx_q[0]); end
      n_cmp++; if (rx_q[1] !== 11'b11111111110) begin n_bad++; $display("FAIL par_FF: got %b want 11111111110", rx_q[1]); end
      n_cmp++; if (rx_q[2] !== 11'b10000000010) begin n_bad++; $display("FAIL par_01: got %b want 10000000010", rx_q[2]); end
      n_cmp++; if (rx_start_q[1] - rx_start_q[0] !== FRAME_CYC) begin n_bad++; $display("FAIL par_frame_period: got %0d want %0d", rx_start_q[1] - rx_start_q[0], FRAME_CYC); end
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL par_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] b;
    logic [10:0] e;
    rx_q.delete(); rx_start_q.delete(); exp_q.delete(); low_err = 0;
    for (int i = 0; i < 17; i++) begin
      b = 8'(53 + i * 11);
      din = b;
      din_valid = 1'b1;
      @(negedge clk);
      if (i < 16) exp_q.push_back(b);
      if (i == 14) begin
        n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_15: got %b want 1", din_ready); end
      end
      if (i == 15) begin
        n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full: got %b want 0", din_ready); end
      end
    end
    din_valid = 1'b0;
    n_cmp++; if (fifo_count !== 5'd16) begin n_bad++; $display("FAIL b2b_count_full: got %0d want 16", fifo_count); end
    wait_rx(16, 16 * FRAME_CYC + 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got %0d frames want 16", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 16; k++) begin
        b = exp_q.pop_front();
        e = {1'b1, ~^b, b, 1'b0};
        n_cmp++; if (rx_q[k] !== e) begin n_bad++; $display("FAIL b2b_frame_%0d: got %b want %b", k, rx_q[k], e); end
      end
      n_cmp++; if (rx_start_q[15] - rx_start_q[0] !== 15 * FRAME_CYC) begin n_bad++; $display("FAIL b2b_span: got %0d want %0d", rx_start_q[15] - rx_start_q[0], 15 * FRAME_CYC); end
    end
    repeat (30) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 16) begin n_bad++; $display("FAIL b2b_dropped_17th: got %0d frames want 16", rx_q.size()); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL b2b_count_end: got %0d want 0", fifo_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_end: got %b want 1", din_ready); end
    n_cmp++; if (low_err !== 0) begin n_bad++; $display("FAIL b2b_low_phase: got %0d bad low phases want 0", low_err); end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    rx_q.delete();
    push_byte(8'hAA);
    t = 0;
    while (!(m_n == 5 && ps2_clk === 1'b0) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    n_cmp++; if (t >= 200) begin n_bad++; $display("FAIL rst_reach_bit4: got timeout want bit 4 low"); end
    n_cmp++; if (ps2_data !== 1'b1) begin n_bad++; $display("FAIL rst_bit4_data: got %b want 1", ps2_data); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (ps2_clk !== 1'b1) begin n_bad++; $display("FAIL rst_mid_clk: got %b want 1", ps2_clk); end
    n_cmp++; if (ps2_data !== 1'b1) begin n_bad++; $display("FAIL rst_mid_data: got %b want 1", ps2_data); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL rst_mid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 0) begin n_bad++; $display("FAIL rst_mid_no_frame: got %0d frames want 0", rx_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: got %b want 0", busy); end
  endtask

  task automatic test_host_inhibit();
    int t;
    int lows;
    int ab0;
    bit ok;
    rx_q.delete(); low_err = 0;
    ab0 = aborts;
    push_byte(8'hF0);
    t = 0;
    while (!(m_n == 5 && ps2_clk === 1'b1) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    n_cmp++; if (t >= 200) begin n_bad++; $display("FAIL inh_reach_bit5: got timeout want bit 5 setup"); end
    host_clk_in = 1'b0;
    lows = 0;
`ifdef PS2_HOST_INHIBIT_EN
    repeat (3) @(negedge clk);
    n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL inh_abort_state: got %0d want 0", dbg_state); end
    n_cmp++; if (ps2_clk !== 1'b1) begin n_bad++; $display("FAIL inh_abort_clk: got %b want 1", ps2_clk); end
    n_cmp++; if (ps2_data !== 1'b1) begin n_bad++; $display("FAIL inh_abort_data: got %b want 1", ps2_data); end
    n_cmp++; if (fifo_count !== 5'd1) begin n_bad++; $display("FAIL inh_no_pop: got %0d want 1", fifo_count); end
    repeat (17) begin
      @(negedge clk);
      if (ps2_clk === 1'b0) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL inh_held_off: got %0d low samples want 0", lows); end
`else
    repeat (20) begin
      @(negedge clk);
      if (ps2_clk === 1'b0) lows++;
    end
    n_cmp++; if (lows !== 9) begin n_bad++; $display("FAIL inh_ignored: got %0d low samples want 9", lows); end
`endif
    host_clk_in = 1'b1;
    wait_rx(1, 300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL inh_timeout: got %0d frames want 1", rx_q.size()); end
    if (ok) begin
      n_cmp++; if (rx_q[0] !== 11'b11111100000) begin n_bad++; $display("FAIL inh_bits_F0: got %b want 11111100000", rx_q[0]); end
    end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL inh_pop: got %0d want 0", fifo_count); end
    repeat (30) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 1) begin n_bad++; $display("FAIL inh_sent_once: got %0d frames want 1", rx_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL inh_busy_end: got %b want 0", busy); end
`ifdef PS2_HOST_INHIBIT_EN
    n_cmp++; if (aborts !== ab0 + 1) begin n_bad++; $display("FAIL inh_abort_seen: got %0d aborts want %0d", aborts - ab0, 1); end
`else
    n_cmp++; if (aborts !== ab0) begin n_bad++; $display("FAIL inh_no_abort: got %0d aborts want 0", aborts - ab0); end
`endif
    n_cmp++; if (low_err !== 0) begin n_bad++; $display("FAIL inh_low_phase: got %0d bad low phases want 0", low_err); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_host_inhibit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
